inv_mix_col_iter: RTL and testbench
===================================

# inv_mix_col_iter

Iterative AES InvMixColumns unit for the decryption datapath. It is the inverse of the combinational forward MixColumns stage. It accepts a 128-bit state over a valid/ready handshake and transforms one 32-bit column per clock, reusing a single column multiplier. It returns the result over a second valid/ready handshake. The block sits between InvShiftRows/InvSubBytes and AddRoundKey in the round-iterative decryptor, where area matters more than throughput.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  128  state; column c is bits [32c+31:32c]; within a column, row 0 is the top byte [32c+31:32c+24].
- out_valid  out  1  out_data holds a finished result.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  128  transformed state, same byte layout as in_data.

## Operation
- Per column a0..a3 (row 0..3), the result is:
  - r0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3
  - r1 = 09·a0 ^ 0E·a1 ^ 0B·a2 ^ 0D·a3
  - r2 = 0D·a0 ^ 09·a1 ^ 0E·a2 ^ 0B·a3
  - r3 = 0B·a0 ^ 0D·a1 ^ 09·a2 ^ 0E·a3
- All products are in GF(2^8) mod x^8+x^4+x^3+x+1 (reduce with 0x1B).
- Single 128-bit state register st. out_data = st. Columns are transformed in place, since each column is independent of the others.
- 2-bit column counter col, counting 0→1→2→3, then clearing to 0.
- FSM states and transitions:
  - IDLE: in_ready=1, out_valid=0. On in_valid: st←in_data, col←0, go BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle: st[col]←invmix(st[col]), col←col+1. At col==3, go DONE.
  - DONE: out_valid=1, in_ready=out_ready.
    - out_ready & in_valid: st←in_data, col←0, go BUSY (back-to-back).
    - out_ready & !in_valid: go IDLE.
    - !out_ready: hold. st, out_valid and out_data stay stable.
- in_valid is ignored in BUSY. Upstream must hold data until in_ready, per the standard valid/ready rule.
- in_data is sampled only on the accepting edge. Later changes to in_data have no effect.
- out_data content outside DONE is don't-care; the bench checks it only when out_valid=1.

## Timing
- Reset values: state=IDLE, col=0, st=0. So in_ready=1, out_valid=0, out_data=0.
- Reset takes effect immediately, asynchronously, in any state. A transform in progress is discarded and no partial result is ever flagged valid.
- Latency: accepting edge at cycle T. Columns 0..3 are written at edges T+1..T+4. out_valid=1 from cycle T+4 (after edge T+4).
- Throughput: one state per 5 cycles with out_ready held high (accept edge + 4 BUSY edges).
- in_ready is combinational from the state and out_ready only. It has no path from in_valid.
- out_valid and out_data are registered, with no combinational path from inputs.
- Simultaneous out handshake and in handshake in DONE: the result is consumed and the new state is loaded on the same edge.

## Structure
- Shared package aes_pkg holds:
  - AES reduction constant 8'h1B.
  - Coefficients 8'h0E, 8'h0B, 8'h0D, 8'h09.
  - FSM state encoding IDLE/BUSY/DONE (2 bits).
- One combinational sub-module, inv_mix_word (32-bit in, 32-bit out).
  - Built from an xtime chain: x2, x4, x8, with 09/0B/0D/0E formed by XOR.
  - It is the only GF logic in the block.
- Top level contains the FSM, the counter, the st register and the column mux/demux.

## Test plan
- Reset: rst high mid-sim → immediately in_ready=1, out_valid=0, out_data=0.
- Known vectors, out_ready=1:
  - Stimulus: in_data=128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6.
  - Response: out_valid rises exactly 4 cycles after accept, with out_data=128'hdb135345_f20a225c_01010101_d4d4d4d5.
- Round trip: 1000 random states → forward MixColumns → this block. The result must equal the original state.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → out_data stable, in_ready=0, out_valid stays 1.
  - Then raise out_ready with in_valid=1 → back-to-back accept; the next result arrives 4 cycles later.
- Reset mid-op: rst asserted at BUSY col=2 → IDLE next; no out_valid pulse. A fresh transform afterwards gives the correct result.
- Input churn: change in_data every cycle during BUSY; in_valid held in BUSY → result matches the value sampled at the accept edge, and there is no extra accept.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the round datapath.
package aes_pkg;

   // Reduction constant for x^8+x^4+x^3+x+1.
   localparam logic [7:0] AES_POLY = 8'h1B;

   // InvMixColumns coefficients.
   localparam logic [7:0] COEF_0E = 8'h0E;
   localparam logic [7:0] COEF_0B = 8'h0B;
   localparam logic [7:0] COEF_0D = 8'h0D;
   localparam logic [7:0] COEF_09 = 8'h09;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Multiply by x (0x02) in GF(2^8).
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   // Product with a 4-bit coefficient, built from a precomputed xtime chain
   // (b, 2b, 4b, 8b). Constant coefficients fold down to plain XOR trees.
   function automatic logic [7:0] gf_pick(input logic [7:0] x1, input logic [7:0] x2,
                                          input logic [7:0] x4, input logic [7:0] x8,
                                          input logic [7:0] coef);
      logic [7:0] p;
      p = 8'h00;
      if (coef[0]) p = p ^ x1;
      if (coef[1]) p = p ^ x2;
      if (coef[2]) p = p ^ x4;
      if (coef[3]) p = p ^ x8;
      return p;
   endfunction

endpackage

// File: rtl/inv_mix_word.sv
// Combinational InvMixColumns of one 32-bit column (row 0 in the top byte).
module inv_mix_word
   import aes_pkg::*;
(
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   logic [7:0] a  [4];
   logic [7:0] x2 [4];
   logic [7:0] x4 [4];
   logic [7:0] x8 [4];
   logic [7:0] m9 [4];
   logic [7:0] mb [4];
   logic [7:0] md [4];
   logic [7:0] me [4];

   // Per-byte xtime chain and the four coefficient multiples.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         a[i]  = word_i[31-8*i -: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = gf_pick(a[i], x2[i], x4[i], x8[i], COEF_09);
         mb[i] = gf_pick(a[i], x2[i], x4[i], x8[i], COEF_0B);
         md[i] = gf_pick(a[i], x2[i], x4[i], x8[i], COEF_0D);
         me[i] = gf_pick(a[i], x2[i], x4[i], x8[i], COEF_0E);
      end
   end

   // Circulant combine: row j takes 0E from itself, then 0B, 0D, 09 rotating down.
   always_comb begin
      word_o = '0;
      for (int j = 0; j < 4; j++) begin
         word_o[31-8*j -: 8] = me[j] ^ mb[(j+1)%4] ^ md[(j+2)%4] ^ m9[(j+3)%4];
      end
   end

endmodule

// File: rtl/inv_mix_col_iter.sv
// Iterative InvMixColumns: one column per clock through a shared column unit,
// valid/ready on both sides, result held in the state register until taken.
module inv_mix_col_iter
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   state_e        state_q, state_d;
   logic [1:0]    col_q, col_d;
   logic [127:0]  st_q, st_d;
   logic [6:0]    col_base;
   logic [31:0]   col_in, col_out;

   assign col_base = {col_q, 5'd0};
   assign col_in   = st_q[col_base +: 32];
   assign out_data = st_q;

   inv_mix_word u_word (
      .word_i (col_in),
      .word_o (col_out)
   );

   // State, column counter and data register.
   // NOTE: st_q is an ordinary register rather than a RAM, so it is cleared on
   // reset like the rest; that makes out_data a defined zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         col_q   <= 2'd0;
         st_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         col_q   <= col_d;
         st_q    <= st_d;
      end
   end

   // Next-state, column write-back and handshake outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // (which would infer a latch).
      state_d   = state_q;
      col_d     = col_q;
      st_d      = st_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               st_d    = in_data;
               col_d   = 2'd0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            st_d[col_base +: 32] = col_out;
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  st_d    = in_data;
                  col_d   = 2'd0;
                  state_d = ST_BUSY;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            col_d   = 2'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_inv_mix_col_iter.sv
// Scoreboard bench for inv_mix_col_iter: known vector, forward/inverse round
// trip, backpressure, asynchronous reset and input churn.
module tb_inv_mix_col_iter;
   import aes_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_data;

   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           acc_cyc = 0;
   int           n_acc = 0;
   logic         prev_ov = 1'b0;
   logic [127:0] exp_next = '0;
   logic [127:0] sb[$];

   localparam logic [127:0] KV_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
   localparam logic [127:0] KV_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

   inv_mix_col_iter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Shift-and-add GF(2^8) multiply.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s, input logic [7:0] c0,
                                        input logic [7:0] c1, input logic [7:0] c2,
                                        input logic [7:0] c3);
      logic [127:0] r;
      logic [7:0]   a [4];
      logic [7:0]   k [4];
      k[0] = c0; k[1] = c1; k[2] = c2; k[3] = c3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) a[i] = s[32*c + 31 - 8*i -: 8];
         for (int j = 0; j < 4; j++) begin
            logic [7:0] acc;
            acc = 8'h00;
            for (int i = 0; i < 4; i++) acc = acc ^ gf_mul(a[i], k[(i - j + 4) % 4]);
            r[32*c + 31 - 8*j -: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] fwd_mix(input logic [127:0] s);
      return mix(s, 8'h02, 8'h03, 8'h01, 8'h01);
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      return mix(s, COEF_0E, COEF_0B, COEF_0D, COEF_09);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Monitor: pop on output handshake, push on input handshake, check latency.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_ov = 1'b0;
         end else begin
            if (out_valid && !prev_ov) check("latency", 128'(cyc - acc_cyc), 128'(4));
            if (out_valid && out_ready) begin
               if (sb.size() == 0) check("spurious_out", 128'(1), 128'(0));
               else check("data", out_data, sb.pop_front());
            end
            if (in_valid && in_ready) begin
               sb.push_back(exp_next);
               acc_cyc = cyc + 1;
               n_acc++;
            end
            prev_ov = out_valid;
         end
      end
   end

   // Presents one state; returns 1ns after the accepting edge with in_valid low.
   task automatic send(input logic [127:0] d, input logic [127:0] e);
      int g;
      g = 0;
      @(posedge clk);
      #1;
      in_data  = d;
      exp_next = e;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      check("accept_tmo", 128'(g < 100), 128'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      @(negedge clk);
      while ((sb.size() != 0 || out_valid) && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("drain_tmo", 128'(g < 50), 128'(1));
   endtask

   task automatic wait_valid();
      int g;
      g = 0;
      @(negedge clk);
      while (!out_valid && g < 20) begin
         @(negedge clk);
         g++;
      end
      check("valid_tmo", 128'(g < 20), 128'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] x, y, held;
      int           acc_before;

      // Power-on reset.
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_data", out_data, '0);
      rst = 1'b0;

      // Known vector.
      send(KV_IN, KV_OUT);
      drain();

      // Round trip through forward MixColumns.
      for (int i = 0; i < 1000; i++) begin
         x = rnd128();
         send(fwd_mix(x), x);
      end
      drain();

      // Backpressure, then simultaneous out/in handshake.
      out_ready = 1'b0;
      x = rnd128();
      send(x, inv_mix(x));
      wait_valid();
      held = out_data;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_data_stable", out_data, held);
         check("bp_in_ready", 128'(in_ready), 128'(0));
         check("bp_out_valid", 128'(out_valid), 128'(1));
      end
      @(posedge clk);
      #1;
      y = rnd128();
      in_data   = y;
      exp_next  = inv_mix(y);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check("b2b_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();

      // Asynchronous reset while holding a finished result.
      out_ready = 1'b0;
      x = rnd128();
      send(x, inv_mix(x));
      wait_valid();
      #2;
      rst = 1'b1;
      #1;
      check("arst_in_ready", 128'(in_ready), 128'(1));
      check("arst_out_valid", 128'(out_valid), 128'(0));
      check("arst_out_data", out_data, '0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;

      // Reset in BUSY at column 2: no result may appear afterwards.
      x = rnd128();
      send(x, inv_mix(x));
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_in_ready", 128'(in_ready), 128'(1));
      check("mid_out_valid", 128'(out_valid), 128'(0));
      check("mid_out_data", out_data, '0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("mid_no_valid", 128'(out_valid), 128'(0));
      end
      x = rnd128();
      send(x, inv_mix(x));
      drain();

      // Input churn during BUSY with in_valid held.
      acc_before = n_acc;
      x = rnd128();
      send(x, inv_mix(x));
      for (int i = 0; i < 4; i++) begin
         in_data  = rnd128();
         in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      drain();
      check("churn_accepts", 128'(n_acc - acc_before), 128'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
